hdlc_rx_frame_ctrl: RTL and testbench
=====================================

Name: hdlc_rx_frame_ctrl

Overview:
Frame-level sequencer for the HDLC receive datapath. Consumes the event strobes from the Rx bit/flag/destuffing front end (flag detected, abort detected, new destuffed byte) and drives the frame-control signals (Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow), tracks frame length, and hands completed frames to the register interface. Sits between the Rx shifter/flag detector and the Rx buffer/register block.

Parameters:
MAX_BYTES, 128, Rx buffer depth in bytes, including the 2 FCS bytes.
MIN_BYTES, 4, minimum legal byte count between flags, including FCS; shorter frames are errored.

Ports:
Clk  input  1  system clock, all logic on posedge.
Rst  input  1  asynchronous, active-low reset.
RxEN  input  1  receiver enable.
Rx_FlagDetect  input  1  one-cycle strobe: flag 01111110 received.
Rx_AbortDetect  input  1  one-cycle strobe: abort pattern (7+ ones) received.
Rx_NewByte  input  1  one-cycle strobe: destuffed byte ready at shifter.
Rx_ReadDone  input  1  one-cycle strobe from register block: frame fully read or dropped.
Rx_ValidFrame  output  1  high while inside a frame (states FRAME, OVERFLOW).
Rx_WrBuff  output  1  one-cycle write strobe to Rx buffer.
Rx_AbortSignal  output  1  one-cycle pulse: frame aborted.
Rx_Overflow  output  1  buffer overflow, held until frame is released.
Rx_FrameError  output  1  one-cycle pulse: short frame discarded.
Rx_EoF  output  1  one-cycle pulse: frame completed.
Rx_Ready  output  1  completed frame available, held until Rx_ReadDone.
Rx_FrameSize  output  8  payload bytes of completed frame (count minus 2 FCS).

Behaviour:
- All outputs registered. Reset: state DISABLED, all outputs 0, byte count 0.
- States: DISABLED, IDLE, FRAME, OVERFLOW, DONE.
- DISABLED: RxEN=1 -> IDLE next cycle.
- RxEN=0 in any state -> DISABLED next cycle; all outputs and count cleared (includes Rx_Ready, Rx_FrameSize).
- IDLE: Rx_FlagDetect -> FRAME, count=0; Rx_ValidFrame rises the cycle after the flag strobe. Bytes and aborts ignored.
- FRAME: Rx_NewByte with count<MAX_BYTES -> count++, Rx_WrBuff high exactly the next cycle. Rx_NewByte with count==MAX_BYTES -> no write, Rx_Overflow=1 next cycle, -> OVERFLOW.
- FRAME, flag with count==0: shared/back-to-back flag, stay in FRAME, no pulses.
- FRAME, flag with 0<count<MIN_BYTES: Rx_FrameError pulse next cycle, stay in FRAME, count=0 (flag reopens).
- FRAME, flag with count>=MIN_BYTES: -> DONE; next cycle Rx_EoF pulse, Rx_Ready=1, Rx_FrameSize=count-2, Rx_ValidFrame=0.
- FRAME or OVERFLOW, Rx_AbortDetect: Rx_AbortSignal pulses the next cycle (always, since Rx_ValidFrame=1); -> IDLE; Rx_ValidFrame and Rx_Overflow cleared; count=0.
- OVERFLOW: bytes ignored (no Rx_WrBuff). Flag -> DONE as above with Rx_FrameSize=MAX_BYTES-2, Rx_Overflow held.
- DONE: flags, bytes, aborts ignored; Rx_ReadDone -> IDLE next cycle; Rx_Ready, Rx_Overflow, Rx_FrameSize cleared.
- Rx_ReadDone outside DONE: ignored.
- Priority on coincident strobes: RxEN=0 > Rx_AbortDetect > Rx_NewByte > Rx_FlagDetect. Abort+byte: byte dropped, no Rx_WrBuff. Byte+flag: byte counted and written first; close decision uses the updated count.
- Count width: clog2(MAX_BYTES+1) bits; cannot exceed MAX_BYTES. MAX_BYTES<=255 for the 8-bit size output.
- Reset mid-frame: immediate async clear, no pulses emitted.

Optional Feature:
RX_LOST_FRAME_CNT_EN: adds output Rx_LostFrames [7:0]. Increments (saturates at 255) on each Rx_FlagDetect in DONE that is not within one cycle of a previous flag. Cleared by reset or RxEN=0. Without the macro: port absent, flags in DONE silently ignored.

Test Plan:
- Flag, 6 bytes, flag -> 6 Rx_WrBuff pulses, each 1 cycle after Rx_NewByte; Rx_EoF pulse; Rx_Ready=1; Rx_FrameSize=4; Rx_ReadDone -> Rx_Ready=0 next cycle.
- Flag, 3 bytes, Rx_AbortDetect -> Rx_AbortSignal high exactly 1 cycle after the abort strobe; Rx_ValidFrame=0; no Rx_EoF; state IDLE.
- Flag, 129 bytes, flag (MAX_BYTES=128) -> 128 writes, Rx_Overflow=1 after byte 129, no 129th write; Rx_FrameSize=126, Rx_Overflow held until Rx_ReadDone.
- Flag, 2 bytes, flag, 5 bytes, flag -> Rx_FrameError pulse at 2nd flag; second frame completes with Rx_FrameSize=3.
- Coincident Rx_NewByte+Rx_FlagDetect at byte 4 -> write occurs, frame closes with Rx_FrameSize=2; coincident abort+byte -> no write, abort pulse.
- RxEN=0 in FRAME with 10 bytes, and Rst low mid-frame -> DISABLED, all outputs 0; re-enable, flag required before any Rx_WrBuff.

Source files
------------

// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame sequencer: turns flag/abort/byte strobes into frame-control strobes and frame hand-off.
// Optional RX_LOST_FRAME_CNT_EN adds Rx_LostFrames, a count of frames flagged while a completed frame awaited readout.
module hdlc_rx_frame_ctrl #(
  parameter int MAX_BYTES = 128,
  parameter int MIN_BYTES = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RxEN,
  input  logic       Rx_FlagDetect,
  input  logic       Rx_AbortDetect,
  input  logic       Rx_NewByte,
  input  logic       Rx_ReadDone,
  output logic       Rx_ValidFrame,
  output logic       Rx_WrBuff,
  output logic       Rx_AbortSignal,
  output logic       Rx_Overflow,
  output logic       Rx_FrameError,
  output logic       Rx_EoF,
  output logic       Rx_Ready,
  output logic [7:0] Rx_FrameSize
`ifdef RX_LOST_FRAME_CNT_EN
  ,
  output logic [7:0] Rx_LostFrames
`endif
);

  // state      | meaning
  // S_DISABLED | receiver off, everything held clear
  // S_IDLE     | hunting for an opening flag
  // S_FRAME    | inside a frame, bytes written to the Rx buffer
  // S_OVERFLOW | buffer full, bytes dropped until closing flag or abort
  // S_DONE     | completed frame waiting for the register block to read it
  typedef enum logic [2:0] {S_DISABLED, S_IDLE, S_FRAME, S_OVERFLOW, S_DONE} state_t;

  localparam int CW = $clog2(MAX_BYTES + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d, cnt_v;
  logic          valid_q, valid_d, wr_q, wr_d, abort_q, abort_d, ovf_q, ovf_d;
  logic          ferr_q, ferr_d, eof_q, eof_d, ready_q, ready_d;
  logic [7:0]    size_q, size_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cnt_v   = count_q;
    valid_d = valid_q;
    wr_d    = 1'b0;
    abort_d = 1'b0;
    ovf_d   = ovf_q;
    ferr_d  = 1'b0;
    eof_d   = 1'b0;
    ready_d = ready_q;
    size_d  = size_q;
    if (!RxEN) begin
      state_d = S_DISABLED;
      count_d = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      ready_d = 1'b0;
      size_d  = '0;
    end else begin
      case (state_q)
        S_DISABLED: state_d = S_IDLE;
        S_IDLE: begin
          if (Rx_FlagDetect) begin
            state_d = S_FRAME;
            count_d = '0;
            valid_d = 1'b1;
          end
        end
        S_FRAME, S_OVERFLOW: begin
          if (Rx_AbortDetect) begin
            state_d = S_IDLE;
            abort_d = 1'b1;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            count_d = '0;
          end else begin
            if (Rx_NewByte && state_q == S_FRAME) begin
              if (count_q < CW'(MAX_BYTES)) begin
                cnt_v = count_q + CW'(1);
                wr_d  = 1'b1;
              end else begin
                ovf_d   = 1'b1;
                state_d = S_OVERFLOW;
              end
            end
            // The close decision sees the byte that arrived with the flag.
            if (Rx_FlagDetect) begin
              if (cnt_v != '0 && cnt_v < CW'(MIN_BYTES)) begin
                ferr_d = 1'b1;
                cnt_v  = '0;
              end else if (cnt_v >= CW'(MIN_BYTES)) begin
                state_d = S_DONE;
                eof_d   = 1'b1;
                ready_d = 1'b1;
                valid_d = 1'b0;
                size_d  = 8'(cnt_v - CW'(2));
              end
            end
            count_d = cnt_v;
          end
        end
        S_DONE: begin
          if (Rx_ReadDone) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            ovf_d   = 1'b0;
            size_d  = '0;
            count_d = '0;
          end
        end
        default: state_d = S_DISABLED;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_DISABLED;
      count_q <= '0;
      valid_q <= 1'b0;
      wr_q    <= 1'b0;
      abort_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      eof_q   <= 1'b0;
      ready_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      wr_q    <= wr_d;
      abort_q <= abort_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      eof_q   <= eof_d;
      ready_q <= ready_d;
      size_q  <= size_d;
    end
  end

  assign Rx_ValidFrame  = valid_q;
  assign Rx_WrBuff      = wr_q;
  assign Rx_AbortSignal = abort_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_FrameError  = ferr_q;
  assign Rx_EoF         = eof_q;
  assign Rx_Ready       = ready_q;
  assign Rx_FrameSize   = size_q;

`ifdef RX_LOST_FRAME_CNT_EN
  logic       flag_prev_q, flag_prev_d;
  logic [7:0] lost_q, lost_d;

  // A flag directly after another is the shared closing/opening flag, not a new frame.
  always_comb begin
    flag_prev_d = RxEN & Rx_FlagDetect;
    lost_d      = lost_q;
    if (!RxEN) begin
      lost_d = '0;
    end else if (state_q == S_DONE && Rx_FlagDetect && !flag_prev_q && lost_q != 8'hFF) begin
      lost_d = lost_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      flag_prev_q <= 1'b0;
      lost_q      <= '0;
    end else begin
      flag_prev_q <= flag_prev_d;
      lost_q      <= lost_d;
    end
  end

  assign Rx_LostFrames = lost_q;
`endif

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Directed bench for hdlc_rx_frame_ctrl: each driven cycle queues the outputs expected after the next edge.
module tb_hdlc_rx_frame_ctrl;
  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       RxEN = 1'b0;
  logic       Rx_FlagDetect = 1'b0, Rx_AbortDetect = 1'b0, Rx_NewByte = 1'b0, Rx_ReadDone = 1'b0;
  logic       Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow;
  logic       Rx_FrameError, Rx_EoF, Rx_Ready;
  logic [7:0] Rx_FrameSize;

  int checks = 0;
  int errors = 0;

  hdlc_rx_frame_ctrl #(.MAX_BYTES(128), .MIN_BYTES(4)) dut (
    .Clk(Clk), .Rst(Rst), .RxEN(RxEN),
    .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_NewByte(Rx_NewByte), .Rx_ReadDone(Rx_ReadDone),
    .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_Overflow(Rx_Overflow),
    .Rx_FrameError(Rx_FrameError), .Rx_EoF(Rx_EoF),
    .Rx_Ready(Rx_Ready), .Rx_FrameSize(Rx_FrameSize)
  );

  always #5 Clk = ~Clk;

  // {valid, wrbuff, abort, overflow, frame_error, eof, ready}
  localparam logic [6:0] Z     = 7'b000_0000;
  localparam logic [6:0] V     = 7'b100_0000;
  localparam logic [6:0] VW    = 7'b110_0000;
  localparam logic [6:0] AB    = 7'b001_0000;
  localparam logic [6:0] VO    = 7'b100_1000;
  localparam logic [6:0] VE    = 7'b100_0100;
  localparam logic [6:0] VWE   = 7'b110_0100;
  localparam logic [6:0] EOFR  = 7'b000_0011;
  localparam logic [6:0] WEOFR = 7'b010_0011;
  localparam logic [6:0] RDY   = 7'b000_0001;
  localparam logic [6:0] EOFRO = 7'b000_1011;
  localparam logic [6:0] RDYO  = 7'b000_1001;

  typedef struct {
    string      tag;
    logic [6:0] flags;
    logic [7:0] size;
  } exp_t;

  exp_t sb[$];

  function automatic logic [6:0] outs();
    return {Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow, Rx_FrameError, Rx_EoF, Rx_Ready};
  endfunction

  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (outs() === e.flags && Rx_FrameSize === e.size)
      else begin
        errors++;
        $error("FAIL %s: got flags=%b size=%0d, expected flags=%b size=%0d",
               e.tag, outs(), Rx_FrameSize, e.flags, e.size);
      end
    end
  end

  // en, flag, abort, byte, read_done for one cycle; expectation is for the outputs after that edge.
  task automatic cyc(input string tag, input logic en, input logic f, input logic a, input logic nb,
                     input logic rd, input logic [6:0] ef, input logic [7:0] es);
    exp_t e;
    @(negedge Clk);
    RxEN = en; Rx_FlagDetect = f; Rx_AbortDetect = a; Rx_NewByte = nb; Rx_ReadDone = rd;
    e.tag = tag; e.flags = ef; e.size = es;
    sb.push_back(e);
    @(posedge Clk);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert (outs() === Z && Rx_FrameSize === 8'd0)
    else begin
      errors++;
      $error("FAIL %s: got flags=%b size=%0d, expected flags=%b size=0", tag, outs(), Rx_FrameSize, Z);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge Clk);
    #1 check_zero("reset_state");
    @(negedge Clk);
    Rst = 1'b1;

    // Good frame of 6 bytes with idle gaps; DONE ignores strobes until read
    cyc("enable",      1, 0, 0, 0, 0, Z, 0);
    cyc("idle_byte",   1, 0, 0, 1, 0, Z, 0);
    cyc("open_flag",   1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 6; i++) begin
      cyc("f1_byte",   1, 0, 0, 1, 0, VW, 0);
      cyc("f1_gap",    1, 0, 0, 0, 0, V, 0);
    end
    cyc("f1_close",    1, 1, 0, 0, 0, EOFR, 8'd4);
    cyc("done_ignore", 1, 1, 1, 1, 0, RDY, 8'd4);
    cyc("done_hold",   1, 0, 0, 0, 0, RDY, 8'd4);
    cyc("f1_read",     1, 0, 0, 0, 1, Z, 0);

    // Abort after 3 bytes, back to IDLE
    cyc("f2_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 3; i++) cyc("f2_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f2_abort",    1, 0, 1, 0, 0, AB, 0);
    cyc("f2_idle_byte",1, 0, 0, 1, 0, Z, 0);
    cyc("f2_idle_rd",  1, 0, 0, 0, 1, Z, 0);

    // Overflow: 129 bytes into a 128-byte buffer
    cyc("f3_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 128; i++) cyc("f3_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f3_byte129",  1, 0, 0, 1, 0, VO, 0);
    cyc("f3_ovf_byte", 1, 0, 0, 1, 0, VO, 0);
    cyc("f3_close",    1, 1, 0, 0, 0, EOFRO, 8'd126);
    cyc("f3_hold",     1, 0, 0, 0, 0, RDYO, 8'd126);
    cyc("f3_read",     1, 0, 0, 0, 1, Z, 0);

    // Shared flag, short frame, then a 5-byte frame
    cyc("f4_open",     1, 1, 0, 0, 0, V, 0);
    cyc("f4_shared",   1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 2; i++) cyc("f4_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f4_short",    1, 1, 0, 0, 0, VE, 0);
    for (int i = 0; i < 5; i++) cyc("f4b_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f4b_close",   1, 1, 0, 0, 0, EOFR, 8'd3);
    cyc("f4b_read",    1, 0, 0, 0, 1, Z, 0);

    // Coincident strobes
    cyc("f5_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 2; i++) cyc("f5_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f5_byte_flag_short", 1, 1, 0, 1, 0, VWE, 0);
    for (int i = 0; i < 3; i++) cyc("f5b_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f5b_byte_flag_close", 1, 1, 0, 1, 0, WEOFR, 8'd2);
    cyc("f5b_read",    1, 0, 0, 0, 1, Z, 0);
    cyc("f6_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 2; i++) cyc("f6_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f6_abort_byte", 1, 0, 1, 1, 0, AB, 0);

    // RxEN drop mid-frame and async reset mid-frame
    cyc("f7_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 10; i++) cyc("f7_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f7_disable",  0, 0, 0, 0, 0, Z, 0);
    cyc("f7_dis_strobes", 0, 1, 0, 1, 0, Z, 0);
    cyc("f7_reenable", 1, 0, 0, 0, 0, Z, 0);
    cyc("f7_no_flag_byte", 1, 0, 0, 1, 0, Z, 0);
    cyc("f8_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 2; i++) cyc("f8_byte", 1, 0, 0, 1, 0, VW, 0);
    @(negedge Clk);
    Rx_NewByte = 1'b1;
    #2 Rst = 1'b0;
    #1 check_zero("async_reset");
    Rx_NewByte = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    cyc("rst_enable",  1, 0, 0, 0, 0, Z, 0);
    cyc("rst_no_flag_byte", 1, 0, 0, 1, 0, Z, 0);
    cyc("f9_open",     1, 1, 0, 0, 0, V, 0);
    for (int i = 0; i < 4; i++) cyc("f9_byte", 1, 0, 0, 1, 0, VW, 0);
    cyc("f9_close",    1, 1, 0, 0, 0, EOFR, 8'd2);
    cyc("f9_read",     1, 0, 0, 0, 1, Z, 0);

    @(negedge Clk);
    Rx_ReadDone = 1'b0;
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
